// File: rtl/fuzzy_duty_scanner_pkg.sv
// Shared types for the multi-channel fuzzy duty scanner: FSM states and
// membership-function indices.
package fuzzy_duty_scanner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FUZZ,
    DEFUZZ,
    WRITE,
    DONE
  } state_t;

  localparam int MF_COLD = 0;
  localparam int MF_WARM = 1;
  localparam int MF_HOT  = 2;
  localparam int MF_NUM  = 3;

endpackage

// File: rtl/fuzzy_duty_scanner_if.sv
// Scan request/status bus of the fuzzy duty scanner; the scanner is the slave.
interface fuzzy_duty_scanner_if #(
  parameter int NUM_CH     = 4,
  parameter int BCD_DIGITS = 2,
  parameter int DUTY_W     = 8
);
  logic                           start;
  logic [NUM_CH*4*BCD_DIGITS-1:0] bcd_in;
  logic                           busy;
  logic                           done;
  logic [NUM_CH*DUTY_W-1:0]       duty;
  logic [NUM_CH-1:0]              bcd_err;
  logic [NUM_CH-1:0]              pwm;

  modport master (output start, bcd_in, input busy, done, duty, bcd_err, pwm);
  modport slave  (input start, bcd_in, output busy, done, duty, bcd_err, pwm);
endinterface

// File: rtl/fuzzy_duty_scanner_pwm_gen.sv
// One PWM channel: shadow duty reloaded at counter wrap, registered compare
// against the shared period counter.
module fuzzy_duty_scanner_pwm_gen #(
  parameter int DUTY_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wrap,
  input  logic [DUTY_W-1:0] i_cnt,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_pwm
);
  logic [DUTY_W-1:0] r_shadow;
  logic              r_pwm;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wrap) r_shadow <= i_duty;
      r_pwm <= (i_cnt < r_shadow);
    end
  end

  assign o_pwm = r_pwm;
endmodule

// File: rtl/fuzzy_duty_scanner.sv
// Snapshots all BCD channels on start, then runs each through a shared
// BCD->binary / fuzzify / defuzzify pipeline, one channel per 4-cycle slot.
module fuzzy_duty_scanner
  import fuzzy_duty_scanner_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          BCD_DIGITS = 2,
  parameter int          DUTY_W     = 8,
  parameter int unsigned BP_LO      = 20,
  parameter int unsigned BP_MID     = 50,
  parameter int unsigned BP_HI      = 80,
  parameter int unsigned D_LO       = 32,
  parameter int unsigned D_MID      = 128,
  parameter int unsigned D_HI       = 240
) (
  input logic               i_clk,
  input logic               i_rst,
  fuzzy_duty_scanner_if.slave bus
);
  localparam int          CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          BCD_W = 4 * BCD_DIGITS;
  localparam int          VAL_W = $clog2(10 ** BCD_DIGITS);
  localparam int          ACC_W = 2 * DUTY_W + 2;
  localparam int unsigned FULL  = (1 << DUTY_W) - 1;
  localparam logic [DUTY_W-1:0] FULL_D  = '1;
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

  state_t                   r_state, w_next;
  logic                     w_busy, w_done;
  logic [CH_W-1:0]          r_ch;
  logic [NUM_CH*BCD_W-1:0]  r_snap;
  logic [VAL_W-1:0]         r_val, w_val;
  logic                     r_err, w_err;
  logic [DUTY_W-1:0]        r_mf [MF_NUM];
  logic [DUTY_W-1:0]        w_mf [MF_NUM];
  logic [DUTY_W-1:0]        r_duty_new, w_duty_new;
  logic [NUM_CH*DUTY_W-1:0] r_duty;
  logic [NUM_CH-1:0]        r_bcd_err, w_pwm;
  logic [BCD_W-1:0]         w_digits;
  logic [3:0]               w_dig;
  logic [31:0]              w_v;
  logic [ACC_W-1:0]         w_acc;
  logic [DUTY_W-1:0]        r_cnt;
  logic                     w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = LOAD;
      LOAD:    begin w_next = FUZZ;   w_busy = 1'b1; end
      FUZZ:    begin w_next = DEFUZZ; w_busy = 1'b1; end
      DEFUZZ:  begin w_next = WRITE;  w_busy = 1'b1; end
      WRITE:   begin
        w_next = (r_ch == LAST_CH) ? DONE : LOAD;
        w_busy = 1'b1;
      end
      DONE:    begin w_next = IDLE;   w_done = 1'b1; end
      default: w_next = IDLE;
    endcase
  end

  // BCD->binary, most significant digit first; invalid digits only raise the flag
  always_comb begin
    w_digits = r_snap[r_ch*BCD_W +: BCD_W];
    w_val    = '0;
    w_err    = 1'b0;
    w_dig    = '0;
    for (int d = BCD_DIGITS - 1; d >= 0; d--) begin
      w_dig = w_digits[d*4 +: 4];
      if (w_dig > 4'd9) w_err = 1'b1;
      w_val = w_val * VAL_W'(10) + VAL_W'(w_dig);
    end
  end

  assign w_v = 32'(r_val);

  always_comb begin
    w_mf[MF_COLD] = '0;
    w_mf[MF_WARM] = '0;
    w_mf[MF_HOT]  = '0;
    if (w_v <= BP_LO) begin
      w_mf[MF_COLD] = FULL_D;
    end else if (w_v <= BP_MID) begin
      w_mf[MF_WARM] = DUTY_W'(((w_v - BP_LO) * FULL) / (BP_MID - BP_LO));
      w_mf[MF_COLD] = FULL_D - w_mf[MF_WARM];
    end else if (w_v < BP_HI) begin
      w_mf[MF_WARM] = DUTY_W'(((BP_HI - w_v) * FULL) / (BP_HI - BP_MID));
      w_mf[MF_HOT]  = FULL_D - w_mf[MF_WARM];
    end else begin
      w_mf[MF_HOT]  = FULL_D;
    end
  end

  assign w_acc = ACC_W'(r_mf[MF_COLD]) * ACC_W'(D_LO)
               + ACC_W'(r_mf[MF_WARM]) * ACC_W'(D_MID)
               + ACC_W'(r_mf[MF_HOT])  * ACC_W'(D_HI);
  assign w_duty_new = DUTY_W'(w_acc / ACC_W'(FULL));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap     <= '0;
      r_ch       <= '0;
      r_val      <= '0;
      r_err      <= 1'b0;
      r_duty_new <= '0;
      r_duty     <= '0;
      r_bcd_err  <= '0;
      for (int i = 0; i < MF_NUM; i++) r_mf[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_snap <= bus.bcd_in;
          r_ch   <= '0;
        end
        LOAD: begin
          r_val <= w_val;
          r_err <= w_err;
        end
        FUZZ:   for (int i = 0; i < MF_NUM; i++) r_mf[i] <= w_mf[i];
        DEFUZZ: r_duty_new <= w_duty_new;
        WRITE: begin
          r_bcd_err[r_ch] <= r_err;
          if (!r_err) r_duty[r_ch*DUTY_W +: DUTY_W] <= r_duty_new;
          if (r_ch != LAST_CH) r_ch <= r_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_wrap = (r_cnt == FULL_D - 1'b1);

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pwm
    fuzzy_duty_scanner_pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_wrap (w_wrap),
      .i_cnt  (r_cnt),
      .i_duty (r_duty[c*DUTY_W +: DUTY_W]),
      .o_pwm  (w_pwm[c])
    );
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.duty    = r_duty;
  assign bus.bcd_err = r_bcd_err;
  assign bus.pwm     = w_pwm;
endmodule

// File: tb/tb_fuzzy_duty_scanner.sv
// Directed bench for fuzzy_duty_scanner with hand-computed expected duties,
// scan timing, error handling, mid-scan reset and PWM shadow behaviour.
module tb_fuzzy_duty_scanner;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fuzzy_duty_scanner_if #(.NUM_CH(4), .BCD_DIGITS(2), .DUTY_W(8)) bus ();

  fuzzy_duty_scanner dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [31:0] bcd);
    int n;
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk("scan_done", 32'(bus.done), 32'd1);
    tick();
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, run, i, highs;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) tick();
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_duty",    32'(bus.duty),    32'd0);
    chk("rst_bcd_err", 32'(bus.bcd_err), 32'd0);
    chk("rst_pwm",     32'(bus.pwm),     32'd0);
    rst = 1'b0;
    tick();

    // Timing, snapshot isolation, ignored re-starts
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    bus.bcd_in = 32'h35_99_50_00;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_at = n; end
      if (n == 4) chk("duty0_before_write", 32'(bus.duty[7:0]), 32'd0);
      if (n == 5) chk("duty0_after_write",  32'(bus.duty[7:0]), 32'd32);
      if (n == 2) bus.bcd_in = 32'h99_99_99_99;
      bus.start = (n == 3 || n == 10);
      tick();
    end
    bus.start = 1'b0;
    chk("done_cycle",      32'(done_at),     32'd17);
    chk("done_pulses",     32'(done_cnt),    32'd1);
    chk("busy_cycles",     32'(busy_cnt),    32'd16);
    chk("idle_after_scan", 32'(bus.busy),    32'd0);
    chk("duty_vec1",       32'(bus.duty),    32'h4F_F0_80_20);
    chk("bcd_err_vec1",    32'(bus.bcd_err), 32'd0);

    // Mixed membership and breakpoint values
    run_scan(32'h00_80_20_65);
    chk("duty_v65", 32'(bus.duty[7:0]),   32'd184);
    chk("duty_v20", 32'(bus.duty[15:8]),  32'd32);
    chk("duty_v80", 32'(bus.duty[23:16]), 32'd240);
    chk("duty_v00", 32'(bus.duty[31:24]), 32'd32);

    // Invalid digit keeps old duty and flags the channel until next scan
    run_scan(32'h00_80_20_50);
    chk("duty_v50", 32'(bus.duty[7:0]), 32'd128);
    run_scan(32'h00_80_20_5A);
    chk("bcd_err_set",   32'(bus.bcd_err),     32'b0001);
    chk("duty_err_kept", 32'(bus.duty[7:0]),   32'd128);
    run_scan(32'h00_80_20_50);
    chk("bcd_err_clear", 32'(bus.bcd_err),     32'd0);

    // Reset during channel-2 DEFUZZ
    bus.bcd_in = 32'h35_99_50_00;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (10) tick();
    chk("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_duty", 32'(bus.duty), 32'd0);
    chk("midrst_pwm",  32'(bus.pwm),  32'd0);
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0; highs = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.pwm != 4'd0) highs++;
    end
    chk("midrst_no_done",  32'(done_cnt), 32'd0);
    chk("midrst_no_busy",  32'(busy_cnt), 32'd0);
    chk("pwm_duty0_const", 32'(highs),    32'd0);

    // PWM: duty 32 settles, then change to 240 inside a high phase
    run_scan(32'h00_00_00_00);
    repeat (300) tick();
    i = 0;
    while (bus.pwm[0] && i < 400) begin tick(); i++; end
    while (!bus.pwm[0] && i < 400) begin tick(); i++; end
    chk("pwm_edge_found", 32'(bus.pwm[0]), 32'd1);
    bus.bcd_in = 32'h00_00_00_99;
    run = 0; i = 0;
    while (bus.pwm[0] && i < 400) begin
      run++;
      bus.start = (i == 2);
      tick();
      i++;
    end
    bus.start = 1'b0;
    chk("duty0_updated",  32'(bus.duty[7:0]), 32'd240);
    chk("pwm_old_high",   32'(run), 32'd32);
    i = 0;
    while (!bus.pwm[0] && i < 400) begin tick(); i++; end
    run = 0; i = 0;
    while (bus.pwm[0] && i < 400) begin run++; tick(); i++; end
    chk("pwm_new_high", 32'(run), 32'd240);
    run = 0; i = 0;
    while (!bus.pwm[0] && i < 400) begin run++; tick(); i++; end
    chk("pwm_new_low",  32'(run), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
